// File: rtl/user_au_pkg.sv
// Shared definitions for the audio decimator: register map, CFG layout and the OBI payloads.
package user_au_pkg;

  localparam int unsigned AuDataW     = 32;
  localparam int unsigned AuObiAddrW  = 32;
  localparam int unsigned AuObiDataW  = 32;

  localparam logic [3:0] AuDecCfgOffset   = 4'h0;
  localparam logic [3:0] AuDecCountOffset = 4'h4;

  localparam int unsigned AuDecLog2fLsb = 0;
  localparam int unsigned AuDecLog2fW   = 3;
  localparam int unsigned AuDecAvgBit   = 8;

  typedef struct packed {
    logic                   avg;
    logic [AuDecLog2fW-1:0] log2f;
  } au_dec_cfg_t;

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [AuObiAddrW-1:0] addr;
    logic [AuObiDataW-1:0] wdata;
  } au_obi_req_t;

  typedef struct packed {
    logic                  gnt;
    logic                  rvalid;
    logic [AuObiDataW-1:0] rdata;
    logic                  err;
  } au_obi_rsp_t;

  function automatic logic [AuDecLog2fW-1:0] sat_log2f(logic [AuDecLog2fW-1:0] v,
                                                       logic [AuDecLog2fW-1:0] mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [AuObiDataW-1:0] cfg_to_rdata(au_dec_cfg_t c);
    logic [AuObiDataW-1:0] r;
    r = '0;
    r[AuDecAvgBit] = c.avg;
    r[AuDecLog2fLsb +: AuDecLog2fW] = c.log2f;
    return r;
  endfunction

endpackage

// File: rtl/user_au_dec_regs.sv
// OBI register slave for the decimator: CFG (RW, saturating log2f) and COUNT (RO output-sample count).
module user_au_dec_regs
  import user_au_pkg::*;
#(
  parameter int unsigned MaxFactorLog2 = 4,
  parameter type obi_req_t = au_obi_req_t,
  parameter type obi_rsp_t = au_obi_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  obi_req_t    obi_req_i,
  output obi_rsp_t    obi_rsp_o,
  input  logic        out_fire,
  output au_dec_cfg_t cfg,
  output logic        cfg_wr
);

  localparam logic [AuDecLog2fW-1:0] MaxLog2f  = AuDecLog2fW'(MaxFactorLog2);
  localparam logic [1:0]             CfgIdx    = AuDecCfgOffset[3:2];
  localparam logic [1:0]             CountIdx  = AuDecCountOffset[3:2];

  logic [1:0]            reg_idx;
  logic [AuObiDataW-1:0] count;
  logic [AuObiDataW-1:0] rdata_q;
  logic [AuObiDataW-1:0] rdata_c;
  logic                  rvalid_q;
  logic                  unused_req_bits;

  assign reg_idx = obi_req_i.addr[3:2];
  assign cfg_wr  = obi_req_i.req && obi_req_i.we && (reg_idx == CfgIdx);
  assign unused_req_bits = ^{obi_req_i.addr[AuObiAddrW-1:4], obi_req_i.addr[1:0],
                             obi_req_i.wdata[AuObiDataW-1:9], obi_req_i.wdata[7:3]};

  // Read mux; unmapped offsets read as zero.
  always_comb begin
    rdata_c = '0;
    case (reg_idx)
      CfgIdx:   rdata_c = cfg_to_rdata(cfg);
      CountIdx: rdata_c = count;
      default:  rdata_c = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg      <= '0;
      count    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= obi_req_i.req;
      if (cfg_wr) begin
        cfg.avg   <= obi_req_i.wdata[AuDecAvgBit];
        cfg.log2f <= sat_log2f(obi_req_i.wdata[AuDecLog2fLsb +: AuDecLog2fW], MaxLog2f);
      end
      if (out_fire) count <= count + AuObiDataW'(1);
      if (obi_req_i.req && !obi_req_i.we) rdata_q <= rdata_c;
    end
  end

  always_comb begin
    obi_rsp_o        = '0;
    obi_rsp_o.gnt    = obi_req_i.req;
    obi_rsp_o.rvalid = rvalid_q;
    obi_rsp_o.rdata  = rdata_q;
    obi_rsp_o.err    = 1'b0;
  end

endmodule

// File: rtl/user_au_decimator.sv
// Power-of-two sample-rate decimator (drop or boxcar average) between the LPF cascade and its consumer.
module user_au_decimator
  import user_au_pkg::*;
#(
  parameter int unsigned MaxFactorLog2 = 4,
  parameter type obi_req_t = au_obi_req_t,
  parameter type obi_rsp_t = au_obi_rsp_t
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  obi_req_t                  obi_req_i,
  output obi_rsp_t                  obi_rsp_o,
  input  logic signed [AuDataW-1:0] data_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic signed [AuDataW-1:0] data_o,
  output logic                      valid_o,
  input  logic                      ready_i
);

  localparam int unsigned AccW = AuDataW + MaxFactorLog2;
  localparam int unsigned PhW  = (MaxFactorLog2 > 0) ? MaxFactorLog2 : 1;

  au_dec_cfg_t              cfg;
  logic                     cfg_wr;
  logic                     in_fire;
  logic                     out_fire;
  logic                     grp_last;
  logic [PhW-1:0]           ph;
  logic [PhW-1:0]           ph_last;
  logic signed [AccW-1:0]   acc;
  logic signed [AccW-1:0]   acc_next;
  logic signed [AuDataW-1:0] avg_val;

  user_au_dec_regs #(
    .MaxFactorLog2 (MaxFactorLog2),
    .obi_req_t     (obi_req_t),
    .obi_rsp_t     (obi_rsp_t)
  ) u_regs (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .obi_req_i (obi_req_i),
    .obi_rsp_o (obi_rsp_o),
    .out_fire  (out_fire),
    .cfg       (cfg),
    .cfg_wr    (cfg_wr)
  );

  assign ready_o  = !valid_o || ready_i;
  assign in_fire  = valid_i && ready_o;
  assign out_fire = valid_o && ready_i;
  assign ph_last  = PhW'((32'd1 << cfg.log2f) - 32'd1);
  assign grp_last = (ph == ph_last);

  // First sample of a group reloads the accumulator instead of adding.
  always_comb begin
    acc_next = (ph == '0) ? AccW'(data_i) : acc + AccW'(data_i);
    avg_val  = AuDataW'(acc_next >>> cfg.log2f);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ph      <= '0;
      acc     <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      // A CFG write restarts the group and swallows a coincident input sample.
      if (cfg_wr) begin
        ph  <= '0;
        acc <= '0;
      end else if (in_fire) begin
        acc <= acc_next;
        ph  <= grp_last ? '0 : ph + PhW'(1);
      end

      if (in_fire && grp_last && !cfg_wr) begin
        data_o  <= cfg.avg ? avg_val : data_i;
        valid_o <= 1'b1;
      end else if (out_fire) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_user_au_decimator.sv
// Directed bench for user_au_decimator: cycle table for pass-through, vector table for decimation, corner sequences.
module tb_user_au_decimator;
  import user_au_pkg::*;

  logic                clk = 1'b0;
  logic                rst_i;
  au_obi_req_t         obi_req;
  au_obi_rsp_t         obi_rsp;
  logic signed [31:0]  data_i;
  logic                valid_i;
  logic                ready_o;
  logic signed [31:0]  data_o;
  logic                valid_o;
  logic                ready_i;

  int checks = 0;
  int errors = 0;
  logic signed [31:0] outq[$];

  always #5 clk = ~clk;

  user_au_decimator dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .obi_req_i (obi_req),
    .obi_rsp_o (obi_rsp),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i)
  );

  // Output-handshake capture.
  always @(posedge clk) begin
    if (!rst_i && valid_o && ready_i) outq.push_back(data_o);
  end

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        ri;
    logic        ev;
    logic [31:0] ed;
    logic        er;
  } cyc_t;

  typedef struct {
    string       name;
    logic [31:0] cfg;
    int          n;
    bit          ramp;
    int          ins[4];
    int          nexp;
    int          exps[2];
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic obi_write(input logic [31:0] addr, input logic [31:0] wdata);
    obi_req.req   = 1'b1;
    obi_req.we    = 1'b1;
    obi_req.addr  = addr;
    obi_req.wdata = wdata;
    @(negedge clk);
    check("wr_gnt", 32'(obi_rsp.gnt), 32'd1);
    tick();
    obi_req = '0;
    check("wr_rvalid", 32'(obi_rsp.rvalid), 32'd1);
  endtask

  task automatic obi_read(input logic [31:0] addr, output logic [31:0] rdata);
    obi_req.req   = 1'b1;
    obi_req.we    = 1'b0;
    obi_req.addr  = addr;
    obi_req.wdata = '0;
    @(negedge clk);
    check("rd_gnt", 32'(obi_rsp.gnt), 32'd1);
    tick();
    obi_req = '0;
    check("rd_rvalid", 32'(obi_rsp.rvalid), 32'd1);
    rdata = obi_rsp.rdata;
  endtask

  task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] r;
    obi_read(addr, r);
    check(name, r, exp);
  endtask

  // Offer each sample until accepted; bounded wait per sample.
  task automatic stream(input int s[$]);
    foreach (s[i]) begin
      bit got;
      int guard;
      got = 1'b0;
      guard = 0;
      valid_i = 1'b1;
      data_i  = 32'(s[i]);
      while (!got && guard < 100) begin
        @(negedge clk);
        got = ready_o;
        tick();
        guard++;
      end
      if (!got) check("stream_timeout", 32'd0, 32'd1);
    end
    valid_i = 1'b0;
    data_i  = '0;
  endtask

  task automatic expect_outs(input string name, input int exp[$]);
    check({name, "_n"}, 32'(outq.size()), 32'(exp.size()));
    foreach (exp[i]) begin
      if (i < outq.size()) check({name, "_val"}, outq[i], 32'(exp[i]));
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [31:0] cfg, input int n, input bit ramp,
                              input int a0, input int a1, input int a2, input int a3,
                              input int nexp, input int e0, input int e1);
    vec_t v;
    v.name = nm; v.cfg = cfg; v.n = n; v.ramp = ramp;
    v.ins[0] = a0; v.ins[1] = a1; v.ins[2] = a2; v.ins[3] = a3;
    v.nexp = nexp; v.exps[0] = e0; v.exps[1] = e1;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cyc_t cyc[10];
    vec_t vecs[5];
    int   q[$];
    int   e[$];

    cyc[0] = '{1'b1, 32'd1, 1'b1, 1'b0, 32'd0, 1'b1};
    cyc[1] = '{1'b1, 32'd2, 1'b1, 1'b1, 32'd1, 1'b1};
    cyc[2] = '{1'b1, 32'd3, 1'b1, 1'b1, 32'd2, 1'b1};
    cyc[3] = '{1'b1, 32'd4, 1'b1, 1'b1, 32'd3, 1'b1};
    cyc[4] = '{1'b0, 32'd0, 1'b1, 1'b1, 32'd4, 1'b1};
    cyc[5] = '{1'b0, 32'd0, 1'b0, 1'b0, 32'd4, 1'b1};
    cyc[6] = '{1'b1, 32'd9, 1'b0, 1'b0, 32'd4, 1'b1};
    cyc[7] = '{1'b0, 32'd0, 1'b0, 1'b1, 32'd9, 1'b0};
    cyc[8] = '{1'b0, 32'd0, 1'b1, 1'b1, 32'd9, 1'b1};
    cyc[9] = '{1'b0, 32'd0, 1'b1, 1'b0, 32'd9, 1'b1};

    vecs[0] = mk("avg4_pos",   32'h102, 4,  1'b0, 10, 20, 30, 41, 1, 25, 0);
    vecs[1] = mk("avg4_neg",   32'h102, 4,  1'b0, -1, -2, -3, -4, 1, -3, 0);
    vecs[2] = mk("drop8_ramp", 32'h003, 16, 1'b1, 0, 0, 0, 0,     2, 8, 16);
    vecs[3] = mk("avg2_mixed", 32'h101, 4,  1'b0, 5, 6, -7, -8,   2, 5, -8);
    vecs[4] = mk("drop4",      32'h002, 4,  1'b0, 11, 22, 33, 44, 1, 44, 0);

    rst_i = 1'b1; valid_i = 1'b0; data_i = '0; ready_i = 1'b1; obi_req = '0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;

    @(negedge clk);
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_data_o", data_o, 32'd0);
    check("rst_ready_o", 32'(ready_o), 32'd1);
    tick();
    read_check("rst_cfg", 32'h0, 32'h0);
    read_check("rst_count", 32'h4, 32'h0);

    // Pass-through timing, cycle by cycle.
    foreach (cyc[i]) begin
      valid_i = cyc[i].v; data_i = cyc[i].d; ready_i = cyc[i].ri;
      @(negedge clk);
      check("pt_valid_o", 32'(valid_o), 32'(cyc[i].ev));
      check("pt_data_o", data_o, cyc[i].ed);
      check("pt_ready_o", 32'(ready_o), 32'(cyc[i].er));
      tick();
    end
    valid_i = 1'b0; ready_i = 1'b1;
    read_check("pt_count", 32'h4, 32'd5);

    // Decimation vectors.
    foreach (vecs[k]) begin
      obi_write(32'h0, vecs[k].cfg);
      outq.delete(); q.delete(); e.delete();
      for (int i = 0; i < vecs[k].n; i++) q.push_back(vecs[k].ramp ? i + 1 : vecs[k].ins[i]);
      for (int i = 0; i < vecs[k].nexp; i++) e.push_back(vecs[k].exps[i]);
      stream(q);
      repeat (4) tick();
      expect_outs(vecs[k].name, e);
    end
    read_check("vec_count", 32'h4, 32'd12);

    // Back-pressure: factor 2 drop, ready_i low for 5 cycles mid-stream.
    obi_write(32'h0, 32'h001);
    outq.delete(); q.delete();
    for (int i = 1; i <= 8; i++) q.push_back(i);
    fork
      stream(q);
      begin
        repeat (2) @(posedge clk);
        #1 ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("bp_valid_o", 32'(valid_o), 32'd1);
          check("bp_data_hold", data_o, 32'd2);
          check("bp_ready_o", 32'(ready_o), 32'd0);
          tick();
        end
        ready_i = 1'b1;
      end
    join
    repeat (6) tick();
    e = {2, 4, 6, 8};
    expect_outs("bp", e);

    // Saturation, read-only COUNT, unmapped offset.
    obi_write(32'h0, 32'h007);
    read_check("cfg_sat", 32'h0, 32'h004);
    obi_write(32'h4, 32'h1234);
    read_check("count_ro", 32'h4, 32'd16);
    read_check("unmapped_rd", 32'h8, 32'h0);

    // CFG write mid-group discards the partial group.
    obi_write(32'h0, 32'h102);
    q = {100, 100, 100};
    stream(q);
    obi_write(32'h0, 32'h102);
    outq.delete();
    q = {4, 8, 12, 16};
    stream(q);
    repeat (4) tick();
    e = {10};
    expect_outs("midgrp", e);

    // CFG write coincident with an input handshake: sample consumed but not accumulated.
    q = {1, 1};
    stream(q);
    outq.delete();
    obi_req.req = 1'b1; obi_req.we = 1'b1; obi_req.addr = 32'h0; obi_req.wdata = 32'h102;
    valid_i = 1'b1; data_i = 32'd999;
    @(negedge clk);
    check("wwin_ready_o", 32'(ready_o), 32'd1);
    tick();
    obi_req = '0; valid_i = 1'b0; data_i = '0;
    q = {4, 8, 12, 16};
    stream(q);
    repeat (4) tick();
    e = {10};
    expect_outs("wwin", e);

    // Reset with an output pending.
    obi_write(32'h0, 32'h101);
    ready_i = 1'b0;
    q = {10, 20};
    stream(q);
    @(negedge clk);
    check("pre_rst_valid", 32'(valid_o), 32'd1);
    check("pre_rst_data", data_o, 32'd15);
    check("pre_rst_ready", 32'(ready_o), 32'd0);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    check("mid_rst_valid_o", 32'(valid_o), 32'd0);
    check("mid_rst_data_o", data_o, 32'd0);
    check("mid_rst_ready_o", 32'(ready_o), 32'd1);
    tick();
    ready_i = 1'b1;
    read_check("mid_rst_count", 32'h4, 32'd0);
    read_check("mid_rst_cfg", 32'h0, 32'h0);
    read_check("mid_rst_unmapped", 32'h8, 32'h0);
    outq.delete();
    q = {7};
    stream(q);
    repeat (3) tick();
    e = {7};
    expect_outs("post_rst", e);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/user_au_decimator.md
# user_au_decimator

Downstream neighbour of the LPF cascade in the audio path. It consumes the low-pass-filtered 32-bit sample stream and reduces the sample rate by a runtime-programmable power-of-two factor, in either drop or boxcar-average mode. Its valid/ready ports connect directly to the cascade output and to the next consumer. Configuration and an output-sample counter are exposed on the shared OBI bus.

## Interface
- `ObiCfg`, default `obi_pkg::ObiDefaultConfig`: OBI configuration.
- `obi_req_t`, default `logic`: OBI request struct.
- `obi_rsp_t`, default `logic`: OBI response struct.
- `MaxFactorLog2`, default 4: largest decimation exponent; factor range is 1..2^MaxFactorLog2.
- `clk_i`, in, 1: the single clock.
- `rst_i`, in, 1: reset, synchronous and active-high.
- `obi_req_i`, in, `obi_req_t`: register access.
- `obi_rsp_o`, out, `obi_rsp_t`: register response.
- `data_i`, in, 32 signed: input sample from the LPF cascade.
- `valid_i`, in, 1: input sample valid.
- `ready_o`, out, 1: block accepts an input sample.
- `data_o`, out, 32 signed: decimated sample.
- `valid_o`, out, 1: output sample valid.
- `ready_i`, in, 1: downstream accepts an output sample.

## Operation
- Registers are decoded on `addr[3:2]`.
  - 0x0 CFG (RW): bits [2:0] = `log2f`, saturated to `MaxFactorLog2` on write; bit [8] = `avg` (0 = drop, 1 = average). Reset value 0, i.e. factor 1 in drop mode, which is a pass-through.
  - 0x4 COUNT (RO): number of output handshakes since reset, 32-bit, wraps 0xFFFFFFFF→0. Writes are ignored.
  - Any other address: reads return 0, writes are ignored, and `err` is 0.
- A write to CFG clears the phase counter and the accumulator. It does not affect a sample already held in the output register.
- Input handshake: `valid_i && ready_o`, with `ready_o = !valid_o || ready_i`.
- Phase counter `ph`, range 0..2^log2f−1, increments on each input handshake.
- Accumulator width is 32+`MaxFactorLog2`, signed. On each accepted sample: if `ph == 0` it loads the sign-extended sample; otherwise it adds the sample.
- When an input handshake occurs with `ph == 2^log2f−1`:
  - `ph` returns to 0.
  - The output register loads `avg ? (acc_next >>> log2f)` (arithmetic shift, floor) : `data_i` (the last sample of the group).
  - `valid_o` is set.
- Output handshake: `valid_o && ready_i` clears `valid_o` and increments COUNT. If a new output loads in the same cycle, `valid_o` stays 1.
- `data_o` holds stable while `valid_o && !ready_i`.

## Timing
- Reset values: `valid_o` = 0, `data_o` = 0, `ready_o` = 1, CFG = 0, COUNT = 0, `ph` = 0, acc = 0. A reset mid-group discards the partial group.
- Latency: `valid_o` rises on the cycle after the handshake of the final sample of a group.
- Throughput: one input per cycle with `ready_i` held high. Back-pressure stalls the input only while an output is pending.
- OBI: `gnt` = `req`, combinational. `rvalid` is asserted exactly one cycle after each granted request, for both reads and writes. `rdata` is registered. A CFG write takes effect from the following cycle.
- A CFG write in the same cycle as an input handshake: the write wins. `ph` and acc clear and the sample is dropped from accumulation (it is still consumed).

## Structure
- Shared package `user_au_pkg`: register offsets (`AuDecCfgOffset` = 0x0, `AuDecCountOffset` = 0x4), CFG field positions, and `au_dec_cfg_t` (`log2f`, `avg`).
- One natural sub-module, `user_au_dec_regs`: the OBI register slave. It outputs `cfg` plus a one-cycle `cfg_wr` pulse and takes an `out_fire` input for COUNT. The datapath (phase counter, accumulator, output register) stays in the top module.

## Test plan
- Reset, then stream 1,2,3,4 with CFG=0 → outputs 1,2,3,4, one cycle after each input; COUNT=4.
- CFG=0x102 (avg, factor 4), inputs 10,20,30,41 → single output 25 (101>>>2); inputs −1,−2,−3,−4 → output −3 (floor).
- CFG=0x003 (drop, factor 8), inputs 1..16 → outputs 8, 16.
- Factor 2 drop mode, `ready_i` held low for 5 cycles while the input is streaming → `ready_o` drops after the first output, `data_o` stays stable, no samples are lost; after release the output sequence is correct.
- Write CFG=0x007 with `MaxFactorLog2`=4 → CFG reads back 0x004. A CFG write mid-group after 3 of 4 samples → the partial group is discarded and the next 4 samples produce one output.
- Assert `rst_i` for one cycle with an output pending and a partial accumulation → all outputs are at reset values next cycle and COUNT=0. A read of 0x8 returns 0 with `rvalid` one cycle after `gnt`.
